// File: rtl/bus_target_mem.sv
// Responder for the 4-bit CPU nibble bus: nibble RAM, 4-word I/O window and a boot loader FSM.
// Latency: reads are combinational (zero cycles); writes and loader transfers commit on the rising edge.
// Backpressure: load_ready is high only while loading; CPU bus writes are dropped unless the FSM is in RUN.
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   bus_addr/bus_data_rw/
//   bus_data_out/bus_data_in      CPU nibble bus (names follow the CPU side)
//   cpu_rst_n                     registered active-low reset to the CPU, high only in RUN
//   load_start/run_req            loader start pulse / release CPU without loading
//   load_valid/load_data/
//   load_last/load_ready          valid/ready boot nibble stream
//   gpio_out/gpio_in              output port register / asynchronous input port
module bus_target_mem #(
  parameter int          RAM_DEPTH = 256,
  parameter logic [11:0] IO_BASE   = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bus_addr,
  input  logic        bus_data_rw,
  input  logic [3:0]  bus_data_out,
  output logic [3:0]  bus_data_in,
  output logic        cpu_rst_n,
  input  logic        load_start,
  input  logic        run_req,
  input  logic        load_valid,
  input  logic [3:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic [3:0]  gpio_out,
  input  logic [3:0]  gpio_in
);

  localparam int               PTR_W   = $clog2(RAM_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAM_DEPTH - 1);

  localparam logic [11:0] ADDR_GPIO_OUT = IO_BASE;
  localparam logic [11:0] ADDR_GPIO_IN  = IO_BASE + 12'd1;
  localparam logic [11:0] ADDR_STATUS   = IO_BASE + 12'd2;
  localparam logic [11:0] ADDR_SCRATCH  = IO_BASE + 12'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             cpu_rst_n_q;
  logic             load_ready_q;
  logic [3:0]       gpio_out_q;
  logic [3:0]       scratch_q;
  logic [3:0]       gpio_sync1_q, gpio_sync2_q;

  logic [3:0]       ram_q [RAM_DEPTH];

  logic             hit_ram;
  logic             cpu_wr;
  logic             load_acc;
  logic             ram_we;
  logic [PTR_W-1:0] ram_waddr;
  logic [3:0]       ram_wdata;

  // RAM occupies the bottom of the map; RAM_DEPTH never exceeds IO_BASE so the cast is safe.
  assign hit_ram = (bus_addr < 12'(RAM_DEPTH));

  // CPU writes are level-sensitive: every edge with rw high commits, so the last edge's data wins.
  assign cpu_wr = (state_q == S_RUN) && bus_data_rw;

  // load_ready_q mirrors state==LOAD exactly; a restart edge swallows any offered nibble.
  assign load_acc = (state_q == S_LOAD) && load_ready_q && load_valid && !load_start;

  // ---------------------------------------------------------------------------
  // Loader FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end else if (run_req) begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          ptr_d = '0;
        end else if (load_acc) begin
          ptr_d = ptr_q + PTR_W'(1);  // wraps naturally at RAM_DEPTH
          if (load_last) begin
            state_d = S_RUN;
          end else if (ptr_q == PTR_MAX) begin
            ovf_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ovf_q        <= ovf_d;
      // Rises one edge after entering RUN, falls on the very edge that leaves RUN.
      cpu_rst_n_q  <= (state_q == S_RUN) && !load_start;
      load_ready_q <= (state_d == S_LOAD);
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port: loader and CPU are mutually exclusive by FSM state
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (load_acc) begin
      ram_we    = 1'b1;
      ram_waddr = ptr_q;
      ram_wdata = load_data;
    end else if (cpu_wr && hit_ram) begin
      ram_we    = 1'b1;
      ram_waddr = bus_addr[PTR_W-1:0];
      ram_wdata = bus_data_out;
    end
  end

  // Contents deliberately survive reset so an aborted load leaves its partial data.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // I/O registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out_q   <= 4'h0;
      scratch_q    <= 4'h0;
      gpio_sync1_q <= 4'h0;
      gpio_sync2_q <= 4'h0;
    end else begin
      gpio_sync1_q <= gpio_in;
      gpio_sync2_q <= gpio_sync1_q;
      if (cpu_wr && (bus_addr == ADDR_GPIO_OUT)) begin
        gpio_out_q <= bus_data_out;
      end
      if (cpu_wr && (bus_addr == ADDR_SCRATCH)) begin
        scratch_q <= bus_data_out;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_data_in = 4'h0;
    if (hit_ram) begin
      bus_data_in = ram_q[bus_addr[PTR_W-1:0]];
    end else begin
      unique case (bus_addr)
        ADDR_GPIO_OUT: bus_data_in = gpio_out_q;
        ADDR_GPIO_IN:  bus_data_in = gpio_sync2_q;
        ADDR_STATUS:   bus_data_in = {1'b0, state_q == S_RUN, state_q == S_LOAD, ovf_q};
        ADDR_SCRATCH:  bus_data_in = scratch_q;
        default:       bus_data_in = 4'h0;
      endcase
    end
  end

  assign cpu_rst_n  = cpu_rst_n_q;
  assign load_ready = load_ready_q;
  assign gpio_out   = gpio_out_q;

endmodule

// File: tb/tb_bus_target_mem.sv
module tb_bus_target_mem;

  localparam int          DEPTH  = 256;
  localparam logic [11:0] IOB    = 12'hFF0;
  localparam int          M_IDLE = 0;
  localparam int          M_LOAD = 1;
  localparam int          M_RUN  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bus_addr = '0;
  logic        bus_data_rw = 1'b0;
  logic [3:0]  bus_data_out = '0;
  logic [3:0]  bus_data_in;
  logic        cpu_rst_n;
  logic        load_start = 1'b0;
  logic        run_req = 1'b0;
  logic        load_valid = 1'b0;
  logic [3:0]  load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [3:0]  gpio_out;
  logic [3:0]  gpio_in = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_mode;
  int         m_ptr;
  bit         m_ovf;
  logic [3:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  logic [3:0] m_gpio, m_s1, m_s2, m_scr;
  bit         m_scr_known;
  bit         m_cpu_rst;

  always #5 clk = ~clk;

  bus_target_mem #(.RAM_DEPTH(DEPTH), .IO_BASE(IOB)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_data_rw(bus_data_rw),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .cpu_rst_n(cpu_rst_n),
    .load_start(load_start), .run_req(run_req), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .gpio_out(gpio_out), .gpio_in(gpio_in)
  );

  function automatic void model_reset();
    m_mode = M_IDLE; m_ptr = 0; m_ovf = 0; m_gpio = 0; m_s1 = 0; m_s2 = 0;
    m_scr_known = 0; m_cpu_rst = 0;
  endfunction

  // Expected read value, or -1 where the model has no defined value.
  function automatic int model_rd(logic [11:0] a);
    if (a < 12'(DEPTH)) return m_known[a[7:0]] ? int'(m_mem[a[7:0]]) : -1;
    if (a == IOB) return int'(m_gpio);
    if (a == IOB + 12'd1) return int'(m_s2);
    if (a == IOB + 12'd2)
      return ((m_mode == M_RUN) ? 4 : 0) + ((m_mode == M_LOAD) ? 2 : 0) + (m_ovf ? 1 : 0);
    if (a == IOB + 12'd3) return m_scr_known ? int'(m_scr) : -1;
    return 0;
  endfunction

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 12'($urandom_range(0, DEPTH - 1));
      3:       return IOB + 12'($urandom_range(0, 3));
      4:       return 12'($urandom_range(DEPTH, 12'hFEF));
      default: return 12'($urandom_range(12'hFF4, 12'hFFF));
    endcase
  endfunction

  // Advance the model by one edge using the inputs currently driven, then clock the DUT.
  task automatic tick();
    int nmode;
    nmode = m_mode;
    if (m_mode == M_RUN && bus_data_rw) begin
      if (bus_addr < 12'(DEPTH)) begin
        m_mem[bus_addr[7:0]] = bus_data_out;
        m_known[bus_addr[7:0]] = 1;
      end else if (bus_addr == IOB) begin
        m_gpio = bus_data_out;
      end else if (bus_addr == IOB + 12'd3) begin
        m_scr = bus_data_out; m_scr_known = 1;
      end
    end
    m_cpu_rst = (m_mode == M_RUN) && !load_start;
    if (m_mode == M_IDLE) begin
      if (load_start) begin nmode = M_LOAD; m_ptr = 0; m_ovf = 0; end
      else if (run_req) nmode = M_RUN;
    end else if (m_mode == M_LOAD) begin
      if (load_start) m_ptr = 0;
      else if (load_valid) begin
        m_mem[m_ptr] = load_data; m_known[m_ptr] = 1;
        if (load_last) nmode = M_RUN;
        else if (m_ptr == DEPTH - 1) m_ovf = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end else begin
      if (load_start) begin nmode = M_LOAD; m_ptr = 0; m_ovf = 0; end
    end
    m_s2 = m_s1; m_s1 = gpio_in;
    m_mode = nmode;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n got %b want 0", cpu_rst_n); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b want 0", load_ready); end
    checks++; if (gpio_out !== 4'h0) begin errors++; $display("FAIL reset_gpio_out got %h want 0", gpio_out); end
    rst_n = 1'b1;
    tick();
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL idle_cpu_rst_n got %b want 0", cpu_rst_n); end
    // Release without loading, set gpio, then reset asynchronously in mid-cycle.
    run_req = 1'b1; tick(); run_req = 1'b0; tick();
    checks++; if (cpu_rst_n !== m_cpu_rst) begin errors++; $display("FAIL run_req_cpu_rst_n got %b want %b", cpu_rst_n, m_cpu_rst); end
    bus_addr = IOB; bus_data_out = 4'hC; bus_data_rw = 1'b1; tick(); bus_data_rw = 1'b0;
    checks++; if (gpio_out !== 4'hC) begin errors++; $display("FAIL gpio_set got %h want c", gpio_out); end
    #2 rst_n = 1'b0; #1;
    model_reset();
    checks++; if (gpio_out !== 4'h0 || cpu_rst_n !== 1'b0 || load_ready !== 1'b0)
      begin errors++; $display("FAIL async_reset got gpio=%h cpu=%b rdy=%b want 0/0/0", gpio_out, cpu_rst_n, load_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_load();
    logic [3:0] nib [3];
    nib[0] = 4'h3; nib[1] = 4'hA; nib[2] = 4'h0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", load_ready); end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = nib[i]; load_last = (i == 2);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL cpu_rst_at_last got %b want 0", cpu_rst_n); end
    tick();
    checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL cpu_rst_after_last got %b want 1", cpu_rst_n); end
    for (int i = 0; i < 3; i++) begin
      bus_addr = 12'(i); #1;
      checks++; if (bus_data_in !== nib[i]) begin errors++; $display("FAIL load_ram[%0d] got %h want %h", i, bus_data_in, nib[i]); end
    end
  endtask

  task automatic test_read();
    bus_addr = 12'h001; #1;
    checks++; if (bus_data_in !== 4'hA) begin errors++; $display("FAIL read_001 got %h want a", bus_data_in); end
    bus_addr = 12'h123; #1;
    checks++; if (bus_data_in !== 4'h0) begin errors++; $display("FAIL read_unmapped got %h want 0", bus_data_in); end
    bus_addr = IOB + 12'd2; #1;
    checks++; if (bus_data_in !== 4'b0100) begin errors++; $display("FAIL read_status_run got %h want 4", bus_data_in); end
  endtask

  task automatic test_write();
    int e;
    bus_addr = IOB; bus_data_rw = 1'b1; bus_data_out = 4'h5; tick();
    bus_data_out = 4'h9; tick(); bus_data_rw = 1'b0;
    checks++; if (gpio_out !== 4'h9) begin errors++; $display("FAIL write_gpio got %h want 9", gpio_out); end
    gpio_in = 4'h6; bus_addr = IOB + 12'd1; tick(); tick();
    checks++; if (bus_data_in !== 4'h6) begin errors++; $display("FAIL gpio_in_sync got %h want 6", bus_data_in); end
    // Random CPU traffic against the model
    for (int i = 0; i < 200; i++) begin
      bus_addr = rand_addr(); bus_data_rw = $urandom_range(0, 1) == 1;
      bus_data_out = 4'($urandom); gpio_in = 4'($urandom);
      tick();
      bus_data_rw = 1'b0;
      checks++; if (gpio_out !== m_gpio) begin errors++; $display("FAIL rnd_gpio_out[%0d] got %h want %h", i, gpio_out, m_gpio); end
      bus_addr = rand_addr(); #1;
      e = model_rd(bus_addr);
      if (e >= 0) begin
        checks++; if (bus_data_in !== 4'(e)) begin errors++; $display("FAIL rnd_read[%0d] addr %h got %h want %h", i, bus_addr, bus_data_in, 4'(e)); end
      end
    end
  endtask

  task automatic test_reload();
    int n, sent, e;
    n = $urandom_range(4, 40);
    load_start = 1'b1; tick(); load_start = 1'b0;
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reload_cpu_rst_drop got %b want 0", cpu_rst_n); end
    sent = 0;
    while (sent < n) begin
      load_valid = $urandom_range(0, 3) != 0; load_data = 4'($urandom);
      load_last = (sent == n - 1);
      if (load_valid) sent++;
      tick();
      checks++; if (load_ready !== (m_mode == M_LOAD)) begin errors++; $display("FAIL reload_ready got %b want %b", load_ready, m_mode == M_LOAD); end
    end
    load_valid = 1'b0; load_last = 1'b0; tick();
    checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL reload_cpu_rst got %b want 1", cpu_rst_n); end
    for (int a = 0; a < n; a++) begin
      bus_addr = 12'(a); #1;
      e = model_rd(bus_addr);
      checks++; if (bus_data_in !== 4'(e)) begin errors++; $display("FAIL reload_ram[%0d] got %h want %h", a, bus_data_in, 4'(e)); end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] first2, last1;
    load_start = 1'b1; tick(); load_start = 1'b0;
    first2 = 4'h0; last1 = 4'h0;
    for (int i = 1; i <= 257; i++) begin
      load_valid = 1'b1; load_data = 4'($urandom);
      if (i == 2) first2 = load_data;
      if (i == 257) last1 = load_data;
      tick();
    end
    load_valid = 1'b0;
    bus_addr = IOB + 12'd2; #1;
    checks++; if (bus_data_in !== 4'b0011) begin errors++; $display("FAIL ovf_status got %h want 3", bus_data_in); end
    bus_addr = 12'h000; #1;
    checks++; if (bus_data_in !== last1) begin errors++; $display("FAIL ovf_ram0 got %h want %h", bus_data_in, last1); end
    bus_addr = 12'h001; #1;
    checks++; if (bus_data_in !== first2) begin errors++; $display("FAIL ovf_ram1 got %h want %h", bus_data_in, first2); end
    checks++; if (load_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin errors++; $display("FAIL ovf_stays_load got rdy=%b cpu=%b want 1/0", load_ready, cpu_rst_n); end
    load_valid = 1'b1; load_data = 4'h7; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0; tick();
    checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL ovf_exit got %b want 1", cpu_rst_n); end
  endtask

  task automatic test_abort();
    logic [3:0] part [5];
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      part[i] = 4'($urandom); load_valid = 1'b1; load_data = part[i]; tick();
    end
    load_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    model_reset();
    checks++; if (load_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin errors++; $display("FAIL abort_outputs got rdy=%b cpu=%b want 0/0", load_ready, cpu_rst_n); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_addr = 12'(i); #1;
      checks++; if (bus_data_in !== part[i]) begin errors++; $display("FAIL abort_ram[%0d] got %h want %h", i, bus_data_in, part[i]); end
    end
    bus_addr = IOB + 12'd2; #1;
    checks++; if (bus_data_in !== 4'h0) begin errors++; $display("FAIL abort_status got %h want 0", bus_data_in); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] keep;
    load_start = 1'b1; run_req = 1'b1; tick(); load_start = 1'b0; run_req = 1'b0;
    bus_addr = IOB + 12'd2; #1;
    checks++; if (bus_data_in !== 4'b0010) begin errors++; $display("FAIL simul_status got %h want 2", bus_data_in); end
    bus_addr = 12'h000; #1; keep = bus_data_in;
    checks++; if (keep !== m_mem[0]) begin errors++; $display("FAIL simul_ram0_before got %h want %h", keep, m_mem[0]); end
    bus_data_rw = 1'b1; bus_data_out = ~m_mem[0];
    repeat (3) tick();
    bus_addr = IOB; tick();
    bus_data_rw = 1'b0;
    checks++; if (gpio_out !== 4'h0) begin errors++; $display("FAIL simul_gpio got %h want 0", gpio_out); end
    bus_addr = 12'h000; #1;
    checks++; if (bus_data_in !== m_mem[0]) begin errors++; $display("FAIL simul_ram0_after got %h want %h", bus_data_in, m_mem[0]); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_known[i] = 0; m_mem[i] = 4'h0; end
    m_scr = 4'h0;
    test_reset();
    test_load();
    test_read();
    test_write();
    test_reload();
    test_overflow();
    test_abort();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
